// File: rtl/nfc_buf_arbiter_if.sv
// Page-buffer sharing bus: host word port, NAND byte-stream port and RAM port.
// Combinational grant in the request cycle; read data one cycle after the read grant.
// Requesters hold their request until granted; the RAM side never stalls.
interface nfc_buf_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 4
);
  // host word port
  logic             h_req;
  logic             h_we;
  logic [ADDR-1:0]  h_addr;
  logic [1:0]       h_be;
  logic [WIDTH-1:0] h_wdata;
  logic             h_gnt;
  logic             h_rvalid;
  logic [WIDTH-1:0] h_rdata;
  // NAND byte-stream port
  logic             n_start;
  logic [ADDR:0]    n_ptr_init;
  logic             n_wreq;
  logic [7:0]       n_wbyte;
  logic             n_wgnt;
  logic             n_rreq;
  logic             n_rgnt;
  logic             n_rvalid;
  logic [7:0]       n_rbyte;
  logic             n_wrap;
  // RAM port
  logic [1:0]       ram_write;
  logic [ADDR-1:0]  ram_addr_wr;
  logic [WIDTH-1:0] ram_data_in;
  logic             ram_read;
  logic [ADDR-1:0]  ram_addr_rd;
  logic [WIDTH-1:0] ram_data_out;

  // Requesters plus the RAM model
  modport master (
    output h_req, h_we, h_addr, h_be, h_wdata,
    output n_start, n_ptr_init, n_wreq, n_wbyte, n_rreq,
    output ram_data_out,
    input  h_gnt, h_rvalid, h_rdata,
    input  n_wgnt, n_rgnt, n_rvalid, n_rbyte, n_wrap,
    input  ram_write, ram_addr_wr, ram_data_in, ram_read, ram_addr_rd
  );

  // The arbiter
  modport slave (
    input  h_req, h_we, h_addr, h_be, h_wdata,
    input  n_start, n_ptr_init, n_wreq, n_wbyte, n_rreq,
    input  ram_data_out,
    output h_gnt, h_rvalid, h_rdata,
    output n_wgnt, n_rgnt, n_rvalid, n_rbyte, n_wrap,
    output ram_write, ram_addr_wr, ram_data_in, ram_read, ram_addr_rd
  );
endinterface

// File: rtl/nfc_buf_arbiter.sv
// Shares the NFC page-buffer RAM between host word accesses and NAND byte stream.
// Grants and RAM strobes combinational in cycle N; read data/rvalid in cycle N+1.
// Losers see no grant and must hold their request; independent round-robin per RAM port.
module nfc_buf_arbiter #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 4,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  nfc_buf_arbiter_if.slave   bus
);

  logic [ADDR:0]   r_ptr;
  logic            r_wlast_nand;
  logic            r_rlast_nand;
  logic            r_h_rvalid;
  logic            r_n_rvalid;
  logic            r_n_rsel;
  logic            r_wrap;

  logic            w_hw_req;
  logic            w_hr_req;
  logic            w_nw_req;
  logic            w_nr_req;
  logic            w_hw_gnt;
  logic            w_hr_gnt;
  logic            w_nw_gnt;
  logic            w_nr_gnt;
  logic [1:0]      w_inc;
  logic [ADDR+1:0] w_ptr_sum;
  logic            w_h_rvalid;
  logic            w_n_rvalid;

  // Request classes; reset blocks everything, n_start blocks the NAND side
  assign w_hw_req = ~rst & bus.h_req & bus.h_we;
  assign w_hr_req = ~rst & bus.h_req & ~bus.h_we;
  assign w_nw_req = ~rst & ~bus.n_start & bus.n_wreq;
  assign w_nr_req = ~rst & ~bus.n_start & bus.n_rreq;

  // Round-robin per port: host wins a conflict when NAND was served last
  assign w_hw_gnt = w_hw_req & (~w_nw_req | r_wlast_nand);
  assign w_nw_gnt = w_nw_req & ~w_hw_gnt;
  assign w_hr_gnt = w_hr_req & (~w_nr_req | r_rlast_nand);
  assign w_nr_gnt = w_nr_req & ~w_hr_gnt;

  // A simultaneous NAND write and read both consume a byte slot
  assign w_inc     = {1'b0, w_nw_gnt} + {1'b0, w_nr_gnt};
  assign w_ptr_sum = {1'b0, r_ptr} + {{ADDR{1'b0}}, w_inc};

  assign bus.h_gnt  = w_hw_gnt | w_hr_gnt;
  assign bus.n_wgnt = w_nw_gnt;
  assign bus.n_rgnt = w_nr_gnt;

  // Reset kills in-flight read returns immediately
  assign w_h_rvalid   = r_h_rvalid & ~rst;
  assign w_n_rvalid   = r_n_rvalid & ~rst;
  assign bus.h_rvalid = w_h_rvalid;
  assign bus.n_rvalid = w_n_rvalid;
  assign bus.h_rdata  = w_h_rvalid ? bus.ram_data_out : '0;
  assign bus.n_rbyte  = w_n_rvalid ? (r_n_rsel ? bus.ram_data_out[15:8] : bus.ram_data_out[7:0]) : 8'h00;
  assign bus.n_wrap   = r_wrap & ~rst;

  // Write-port steering: host word with byte enables, or NAND byte replicated to both lanes
  always_comb begin
    bus.ram_write   = 2'b00;
    bus.ram_addr_wr = '0;
    bus.ram_data_in = '0;
    if (w_hw_gnt) begin
      bus.ram_write   = bus.h_be;
      bus.ram_addr_wr = bus.h_addr;
      bus.ram_data_in = bus.h_wdata;
    end else if (w_nw_gnt) begin
      bus.ram_write   = r_ptr[0] ? 2'b10 : 2'b01;
      bus.ram_addr_wr = r_ptr[ADDR:1];
      bus.ram_data_in = {2{bus.n_wbyte}};
    end
  end

  // Read-port steering: address from host or from the byte pointer's word part
  always_comb begin
    bus.ram_read    = 1'b0;
    bus.ram_addr_rd = '0;
    if (w_hr_gnt) begin
      bus.ram_read    = 1'b1;
      bus.ram_addr_rd = bus.h_addr;
    end else if (w_nr_gnt) begin
      bus.ram_read    = 1'b1;
      bus.ram_addr_rd = r_ptr[ADDR:1];
    end
  end

  // Last-served flags and read-return pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wlast_nand <= 1'b1;
      r_rlast_nand <= 1'b1;
      r_h_rvalid   <= 1'b0;
      r_n_rvalid   <= 1'b0;
      r_n_rsel     <= 1'b0;
    end else begin
      if (w_hw_gnt)      r_wlast_nand <= 1'b0;
      else if (w_nw_gnt) r_wlast_nand <= 1'b1;
      if (w_hr_gnt)      r_rlast_nand <= 1'b0;
      else if (w_nr_gnt) r_rlast_nand <= 1'b1;
      r_h_rvalid <= w_hr_gnt;
      r_n_rvalid <= w_nr_gnt;
      if (w_nr_gnt) r_n_rsel <= r_ptr[0];
    end
  end

  // Byte pointer: load on n_start, else advance by granted NAND bytes modulo 2*DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_wrap <= 1'b0;
    end else if (bus.n_start) begin
      r_ptr  <= bus.n_ptr_init;
      r_wrap <= 1'b0;
    end else begin
      r_ptr  <= w_ptr_sum[ADDR:0];
      r_wrap <= (w_ptr_sum >= (ADDR+2)'(2*DEPTH));
    end
  end

endmodule

// File: tb/tb_nfc_buf_arbiter.sv
module tb_nfc_buf_arbiter;

  localparam int WIDTH = 16;
  localparam int ADDR  = 4;
  localparam int DEPTH = 16;
  localparam int NBYTE = 2 * DEPTH;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  int   cyc;

  nfc_buf_arbiter_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

  nfc_buf_arbiter #(.WIDTH(WIDTH), .ADDR(ADDR), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Page-buffer RAM: byte writes, registered read address
  logic [15:0] ram [DEPTH] = '{default: '0};
  logic [3:0]  ram_ra = '0;
  always @(posedge clk) begin
    if (bus.ram_write[0]) ram[bus.ram_addr_wr][7:0]  <= bus.ram_data_in[7:0];
    if (bus.ram_write[1]) ram[bus.ram_addr_wr][15:8] <= bus.ram_data_in[15:8];
    if (bus.ram_read)     ram_ra <= bus.ram_addr_rd;
  end
  assign bus.ram_data_out = ram[ram_ra];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cyc%0d %s: got %h expected %h", cyc, nm, act, exp);
    end
  endtask

  // ---------------- reference model (byte-array view of the buffer) ----------------
  logic [7:0] mb [NBYTE];
  int         m_ptr;
  bit         m_wlast_nand, m_rlast_nand;
  bit         m_hpend, m_npend, m_wrap;
  logic [15:0] m_hdat;
  logic [7:0]  m_nbyte;

  task automatic model_cycle(input bit do_chk);
    bit hw, hr, nw, nr, hwg, nwg, hrg, nrg;
    bit e_hv, e_nv, e_wr, e_rr;
    logic [1:0]  e_rw;
    logic [3:0]  e_wa, e_ra;
    logic [15:0] e_wd, e_hd;
    logic [7:0]  e_nb;
    int a, p, s;
    e_hv = !rst && m_hpend; e_hd = m_hdat;
    e_nv = !rst && m_npend; e_nb = m_nbyte;
    e_wr = !rst && m_wrap;
    e_rw = 2'b00; e_wa = '0; e_wd = '0; e_rr = 1'b0; e_ra = '0;
    hw = !rst && bus.h_req && bus.h_we;
    hr = !rst && bus.h_req && !bus.h_we;
    nw = !rst && !bus.n_start && bus.n_wreq;
    nr = !rst && !bus.n_start && bus.n_rreq;
    hwg = hw && (!nw || m_wlast_nand);
    nwg = nw && !hwg;
    hrg = hr && (!nr || m_rlast_nand);
    nrg = nr && !hrg;
    p = m_ptr;
    if (hwg) begin
      a = int'(bus.h_addr);
      e_rw = bus.h_be; e_wa = bus.h_addr; e_wd = bus.h_wdata;
      if (bus.h_be[0]) mb[2*a]   = bus.h_wdata[7:0];
      if (bus.h_be[1]) mb[2*a+1] = bus.h_wdata[15:8];
    end else if (nwg) begin
      e_rw = (p % 2 == 1) ? 2'b10 : 2'b01;
      e_wa = 4'(p / 2);
      e_wd = {bus.n_wbyte, bus.n_wbyte};
      mb[p] = bus.n_wbyte;
    end
    m_hpend = 1'b0; m_npend = 1'b0;
    if (hrg) begin
      a = int'(bus.h_addr);
      e_rr = 1'b1; e_ra = bus.h_addr;
      m_hpend = 1'b1; m_hdat = {mb[2*a+1], mb[2*a]};
    end else if (nrg) begin
      e_rr = 1'b1; e_ra = 4'(p / 2);
      m_npend = 1'b1; m_nbyte = mb[p];
    end
    if (do_chk) begin
      chk("h_gnt", 32'(bus.h_gnt), 32'(hwg || hrg));
      chk("n_wgnt", 32'(bus.n_wgnt), 32'(nwg));
      chk("n_rgnt", 32'(bus.n_rgnt), 32'(nrg));
      chk("ram_write", 32'(bus.ram_write), 32'(e_rw));
      chk("ram_read", 32'(bus.ram_read), 32'(e_rr));
      chk("h_rvalid", 32'(bus.h_rvalid), 32'(e_hv));
      chk("n_rvalid", 32'(bus.n_rvalid), 32'(e_nv));
      chk("n_wrap", 32'(bus.n_wrap), 32'(e_wr));
      if (hwg || nwg) begin
        chk("ram_addr_wr", 32'(bus.ram_addr_wr), 32'(e_wa));
        chk("ram_data_in", 32'(bus.ram_data_in), 32'(e_wd));
      end
      if (e_rr) chk("ram_addr_rd", 32'(bus.ram_addr_rd), 32'(e_ra));
      if (e_hv) chk("h_rdata", 32'(bus.h_rdata), 32'(e_hd));
      if (e_nv) chk("n_rbyte", 32'(bus.n_rbyte), 32'(e_nb));
    end
    if (rst) begin
      m_ptr = 0; m_wlast_nand = 1'b1; m_rlast_nand = 1'b1;
      m_hpend = 1'b0; m_npend = 1'b0; m_wrap = 1'b0;
    end else begin
      if (hwg) m_wlast_nand = 1'b0; else if (nwg) m_wlast_nand = 1'b1;
      if (hrg) m_rlast_nand = 1'b0; else if (nrg) m_rlast_nand = 1'b1;
      if (bus.n_start) begin
        m_ptr = int'(bus.n_ptr_init); m_wrap = 1'b0;
      end else begin
        s = p + int'(nwg) + int'(nrg);
        m_wrap = (s >= NBYTE);
        m_ptr = s % NBYTE;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        rst;
    logic        hreq;
    logic        hwe;
    logic [3:0]  haddr;
    logic [1:0]  hbe;
    logic [15:0] hwd;
    logic        nst;
    logic [4:0]  npi;
    logic        nwr;
    logic [7:0]  nwb;
    logic        nrr;
    logic        hg;
    logic        wg;
    logic        rg;
    logic [1:0]  rw;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        rr;
    logic [3:0]  ra;
    logic        hv;
    logic [15:0] hd;
    logic        nv;
    logic [7:0]  nb;
    logic        wr;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl [NV];

  task automatic apply(input vec_t v);
    rst            = v.rst;
    bus.h_req      = v.hreq;  bus.h_we   = v.hwe;  bus.h_addr = v.haddr;
    bus.h_be       = v.hbe;   bus.h_wdata = v.hwd;
    bus.n_start    = v.nst;   bus.n_ptr_init = v.npi;
    bus.n_wreq     = v.nwr;   bus.n_wbyte = v.nwb; bus.n_rreq = v.nrr;
  endtask

  task automatic check_row(input vec_t v);
    chk("t.h_gnt", 32'(bus.h_gnt), 32'(v.hg));
    chk("t.n_wgnt", 32'(bus.n_wgnt), 32'(v.wg));
    chk("t.n_rgnt", 32'(bus.n_rgnt), 32'(v.rg));
    chk("t.ram_write", 32'(bus.ram_write), 32'(v.rw));
    chk("t.ram_read", 32'(bus.ram_read), 32'(v.rr));
    chk("t.h_rvalid", 32'(bus.h_rvalid), 32'(v.hv));
    chk("t.n_rvalid", 32'(bus.n_rvalid), 32'(v.nv));
    chk("t.n_wrap", 32'(bus.n_wrap), 32'(v.wr));
    if (v.rw != 2'b00 || v.wg || (v.hg && v.hwe)) begin
      chk("t.ram_addr_wr", 32'(bus.ram_addr_wr), 32'(v.wa));
      chk("t.ram_data_in", 32'(bus.ram_data_in), 32'(v.wd));
    end
    if (v.rr) chk("t.ram_addr_rd", 32'(bus.ram_addr_rd), 32'(v.ra));
    if (v.hv) chk("t.h_rdata", 32'(bus.h_rdata), 32'(v.hd));
    if (v.nv) chk("t.n_rbyte", 32'(bus.n_rbyte), 32'(v.nb));
  endtask

  initial begin
    vec_t v;
    n_chk = 0; n_err = 0; cyc = 0;
    m_ptr = 0; m_wlast_nand = 1'b1; m_rlast_nand = 1'b1;
    m_hpend = 1'b0; m_npend = 1'b0; m_wrap = 1'b0; m_hdat = '0; m_nbyte = '0;
    for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;

    //           rst req we adr be wdata   st pi nw byte nr | hg wg rg rw wa wd      rr ra hv hd      nv nb  wr
    tbl[0]  = '{1, 0, 0, 0,  0, 0,       0, 0, 0, 0,    0,   0, 0, 0, 0, 0,  0,       0, 0,  0, 0,       0, 0,    0};
    tbl[1]  = '{0, 1, 1, 3,  3, 'hA55A,  0, 0, 0, 0,    0,   1, 0, 0, 3, 3,  'hA55A,  0, 0,  0, 0,       0, 0,    0};
    tbl[2]  = '{0, 1, 0, 3,  0, 0,       0, 0, 0, 0,    0,   1, 0, 0, 0, 0,  0,       1, 3,  0, 0,       0, 0,    0};
    tbl[3]  = '{0, 0, 0, 0,  0, 0,       0, 0, 0, 0,    0,   0, 0, 0, 0, 0,  0,       0, 0,  1, 'hA55A,  0, 0,    0};
    tbl[4]  = '{0, 0, 0, 0,  0, 0,       1, 0, 0, 0,    0,   0, 0, 0, 0, 0,  0,       0, 0,  0, 0,       0, 0,    0};
    tbl[5]  = '{0, 0, 0, 0,  0, 0,       0, 0, 1, 'h11, 0,   0, 1, 0, 1, 0,  'h1111,  0, 0,  0, 0,       0, 0,    0};
    tbl[6]  = '{0, 0, 0, 0,  0, 0,       0, 0, 1, 'h22, 0,   0, 1, 0, 2, 0,  'h2222,  0, 0,  0, 0,       0, 0,    0};
    tbl[7]  = '{0, 1, 0, 0,  0, 0,       0, 0, 0, 0,    0,   1, 0, 0, 0, 0,  0,       1, 0,  0, 0,       0, 0,    0};
    tbl[8]  = '{0, 0, 0, 0,  0, 0,       0, 0, 0, 0,    0,   0, 0, 0, 0, 0,  0,       0, 0,  1, 'h2211,  0, 0,    0};
    tbl[9]  = '{0, 1, 1, 5,  3, 'h1234,  0, 0, 1, 'h33, 0,   1, 0, 0, 3, 5,  'h1234,  0, 0,  0, 0,       0, 0,    0};
    tbl[10] = '{0, 1, 1, 5,  3, 'h1234,  0, 0, 1, 'h33, 0,   0, 1, 0, 1, 1,  'h3333,  0, 0,  0, 0,       0, 0,    0};
    tbl[11] = '{0, 1, 1, 6,  3, 'hBEEF,  0, 0, 1, 'h44, 0,   1, 0, 0, 3, 6,  'hBEEF,  0, 0,  0, 0,       0, 0,    0};
    tbl[12] = '{0, 1, 1, 6,  3, 'hBEEF,  0, 0, 1, 'h44, 0,   0, 1, 0, 2, 1,  'h4444,  0, 0,  0, 0,       0, 0,    0};
    tbl[13] = '{0, 1, 0, 1,  0, 0,       0, 0, 1, 'h55, 0,   1, 1, 0, 1, 2,  'h5555,  1, 1,  0, 0,       0, 0,    0};
    tbl[14] = '{0, 1, 1, 15, 2, 'hC35A,  0, 0, 0, 0,    0,   1, 0, 0, 2, 15, 'hC35A,  0, 0,  1, 'h4433,  0, 0,    0};
    tbl[15] = '{0, 0, 0, 0,  0, 0,       1, 31,0, 0,    0,   0, 0, 0, 0, 0,  0,       0, 0,  0, 0,       0, 0,    0};
    tbl[16] = '{0, 0, 0, 0,  0, 0,       0, 0, 0, 0,    1,   0, 0, 1, 0, 0,  0,       1, 15, 0, 0,       0, 0,    0};
    tbl[17] = '{0, 0, 0, 0,  0, 0,       0, 0, 0, 0,    0,   0, 0, 0, 0, 0,  0,       0, 0,  0, 0,       1, 'hC3, 1};
    tbl[18] = '{0, 0, 0, 0,  0, 0,       0, 0, 0, 0,    0,   0, 0, 0, 0, 0,  0,       0, 0,  0, 0,       0, 0,    0};
    tbl[19] = '{0, 1, 0, 1,  0, 0,       0, 0, 0, 0,    0,   1, 0, 0, 0, 0,  0,       1, 1,  0, 0,       0, 0,    0};
    tbl[20] = '{1, 1, 0, 1,  0, 0,       0, 0, 0, 0,    0,   0, 0, 0, 0, 0,  0,       0, 0,  0, 0,       0, 0,    0};
    tbl[21] = '{0, 1, 0, 1,  0, 0,       0, 0, 0, 0,    0,   1, 0, 0, 0, 0,  0,       1, 1,  0, 0,       0, 0,    0};
    tbl[22] = '{0, 0, 0, 0,  0, 0,       0, 0, 0, 0,    0,   0, 0, 0, 0, 0,  0,       0, 0,  1, 'h4433,  0, 0,    0};
    tbl[23] = '{0, 1, 1, 2,  0, 'hFFFF,  0, 0, 0, 0,    0,   1, 0, 0, 0, 2,  'hFFFF,  0, 0,  0, 0,       0, 0,    0};
    tbl[24] = '{0, 1, 1, 9,  3, 'h0909,  1, 2, 1, 'h77, 1,   1, 0, 0, 3, 9,  'h0909,  0, 0,  0, 0,       0, 0,    0};
    tbl[25] = '{0, 0, 0, 0,  0, 0,       0, 0, 0, 0,    1,   0, 0, 1, 0, 0,  0,       1, 1,  0, 0,       0, 0,    0};
    tbl[26] = '{0, 0, 0, 0,  0, 0,       1, 0, 0, 0,    1,   0, 0, 0, 0, 0,  0,       0, 0,  0, 0,       1, 'h33, 0};
    tbl[27] = '{0, 0, 0, 0,  0, 0,       0, 0, 1, 'h66, 1,   0, 1, 1, 1, 0,  'h6666,  1, 0,  0, 0,       0, 0,    0};
    tbl[28] = '{0, 0, 0, 0,  0, 0,       0, 0, 0, 0,    1,   0, 0, 1, 0, 0,  0,       1, 1,  0, 0,       1, 'h66, 0};
    tbl[29] = '{0, 0, 0, 0,  0, 0,       0, 0, 0, 0,    0,   0, 0, 0, 0, 0,  0,       0, 0,  0, 0,       1, 'h33, 0};
    tbl[30] = '{0, 1, 0, 0,  0, 0,       0, 0, 0, 0,    1,   1, 0, 0, 0, 0,  0,       1, 0,  0, 0,       0, 0,    0};
    tbl[31] = '{0, 1, 0, 0,  0, 0,       0, 0, 0, 0,    1,   0, 0, 1, 0, 0,  0,       1, 1,  1, 'h2266,  0, 0,    0};
    tbl[32] = '{0, 1, 0, 0,  0, 0,       0, 0, 0, 0,    0,   1, 0, 0, 0, 0,  0,       1, 0,  0, 0,       1, 'h44, 0};
    tbl[33] = '{0, 0, 0, 0,  0, 0,       0, 0, 0, 0,    0,   0, 0, 0, 0, 0,  0,       0, 0,  1, 'h2266,  0, 0,    0};

    // Initial reset for a couple of cycles
    apply(tbl[0]);
    repeat (2) @(posedge clk);
    #1;

    // Directed table, one row per cycle; the model tracks state silently
    for (int i = 0; i < NV; i++) begin
      cyc = i;
      apply(tbl[i]);
      @(negedge clk);
      check_row(tbl[i]);
      model_cycle(1'b0);
      @(posedge clk);
      #1;
    end

    // Randomised traffic checked against the byte-array model
    for (int i = 0; i < 3000; i++) begin
      cyc = NV + i;
      v = '0;
      v.rst   = ($urandom_range(0, 99) < 2);
      v.hreq  = $urandom_range(0, 1);
      v.hwe   = $urandom_range(0, 1);
      v.haddr = 4'($urandom);
      v.hbe   = 2'($urandom);
      v.hwd   = 16'($urandom);
      v.nst   = ($urandom_range(0, 15) == 0);
      v.npi   = 5'($urandom);
      v.nwr   = $urandom_range(0, 1);
      v.nwb   = 8'($urandom);
      v.nrr   = $urandom_range(0, 1);
      apply(v);
      @(negedge clk);
      model_cycle(1'b1);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/nfc_buf_arbiter.md
Name: nfc_buf_arbiter

Overview:
- Single-clock controller that shares the NFC page-buffer RAM (16-bit words, byte write enables, registered read address) between two requesters.
- The host bus side makes word accesses with byte enables.
- The NAND byte-stream engine side makes sequential byte accesses through an internal byte pointer.
- Round-robin arbitration runs independently on the RAM write port and the RAM read port. The block also steers bytes in both directions: it packs NAND bytes into words on write and selects the correct byte on read.

Parameters:
- WIDTH, 16, RAM word width (fixed at 16; byte steering assumes 2 bytes per word).
- ADDR, 4, RAM word address width.
- DEPTH, 16, RAM depth in words (2**ADDR).

Ports:
- clk  in  1  block clock; also drives the RAM wclk/rclk.
- rst  in  1  synchronous, active-high reset.
- h_req  in  1  host access request; held until h_gnt.
- h_we  in  1  1=write, 0=read; stable while h_req is high.
- h_addr  in  ADDR  host word address.
- h_be  in  2  host byte enables ([0]=bits 7:0, [1]=bits 15:8).
- h_wdata  in  WIDTH  host write data.
- h_gnt  out  1  host request accepted this cycle.
- h_rvalid  out  1  host read data valid.
- h_rdata  out  WIDTH  host read data.
- n_start  in  1  load byte pointer from n_ptr_init.
- n_ptr_init  in  ADDR+1  initial byte pointer.
- n_wreq  in  1  NAND byte write request.
- n_wbyte  in  8  NAND write byte.
- n_wgnt  out  1  NAND write accepted.
- n_rreq  in  1  NAND byte read request.
- n_rgnt  out  1  NAND read accepted.
- n_rvalid  out  1  NAND read byte valid.
- n_rbyte  out  8  NAND read byte.
- n_wrap  out  1  one-cycle pulse when the byte pointer wraps to 0.
- ram_write  out  2  RAM byte write strobes.
- ram_addr_wr  out  ADDR  RAM write address.
- ram_data_in  out  WIDTH  RAM write data.
- ram_read  out  1  RAM read strobe (captures read address).
- ram_addr_rd  out  ADDR  RAM read address.
- ram_data_out  in  WIDTH  RAM read data, valid the cycle after ram_read.

Behaviour:
- Reset: all outputs 0; byte pointer 0; both round-robin "last served" flags set to NAND, so the host wins the first conflict.
- Host requester classes: a host write competes on the write port only; a host read competes on the read port only.
- Grants are combinational in cycle N from that cycle's requests. The RAM strobes for the winner are driven in the same cycle N, and the RAM captures them at the end of cycle N.
- Round-robin, per port:
  - Only one requester active: it wins.
  - Both active: the one not served last on that port wins.
  - The last-served flag updates only on a grant.
  - The write and read ports may each grant in the same cycle, giving up to two grants per cycle.
- Host write grant:
  - ram_write=h_be, ram_addr_wr=h_addr, ram_data_in=h_wdata.
  - h_be=2'b00 is still granted and drives no strobes.
- NAND write grant:
  - Address and strobe: ram_addr_wr=ptr[ADDR:1]; ram_write=2'b01 if ptr[0]=0, 2'b10 if ptr[0]=1.
  - Data: ram_data_in={n_wbyte,n_wbyte}.
  - The pointer increments.
- Read grant (either requester):
  - ram_read=1 and ram_addr_rd set in cycle N.
  - In cycle N+1 the requester's rvalid=1.
  - Host read: h_rdata=ram_data_out.
  - NAND read: n_rbyte is ram_data_out[7:0] or [15:8], selected by ptr[0] registered at grant. The pointer increments at grant.
  - Reads pipeline back-to-back at one per cycle; rvalid is high on consecutive cycles.
- A NAND write and a NAND read granted in the same cycle:
  - Both use the current ptr.
  - The pointer increments by 2.
  - The write goes to ptr and the read comes from ptr.
- Byte pointer:
  - Width ADDR+1, range 0 to 2*DEPTH-1.
  - It wraps modulo 2*DEPTH.
  - n_wrap pulses in the cycle after an increment that crosses to 0.
- n_start has priority over NAND requests in the same cycle:
  - n_wgnt and n_rgnt are forced to 0 that cycle, so the host wins any contested port.
  - The pointer is loaded at the clock edge.
  - A NAND read granted before n_start still returns its rvalid and byte in the next cycle.
- Reset mid-operation takes effect at the next edge:
  - An in-flight read does not return; rvalid is 0 after reset.
  - Grants and strobes are 0 while rst=1.
- Requests are ignored (no grant) while rst=1. A held request is re-arbitrated after reset is released.

Test Plan:
- Host write addr 3, be=2'b11, data 16'hA55A, then host read addr 3 -> h_gnt high in each request cycle; h_rvalid one cycle after the read grant with h_rdata=16'hA55A.
- n_start with ptr_init 0, then NAND writes 8'h11, 8'h22 -> ram_write 01 then 10 at word 0, ram_data_in 16'h1111 then 16'h2222; host read word 0 returns 16'h2211.
- Host write and NAND write requested continuously for 4 cycles -> grants alternate host, NAND, host, NAND; pointer increments twice.
- n_ptr_init=2*DEPTH-1, NAND read -> reads word DEPTH-1, upper byte; pointer becomes 0; n_wrap pulses one cycle after the grant.
- Host read plus NAND write in the same cycle -> both granted; ram_read and ram_write active together; no stall.
- rst asserted the cycle after a host read grant -> h_rvalid stays 0; all strobes 0; after release the held h_req is granted again.
